multicycle_control: RTL and testbench

//  Main control FSM of the 16-bit multicycle processor; sits directly upstream of ALUControl.

---
 rtl/cpu_ctrl_pkg.sv | 57 +++++
 rtl/multicycle_control.sv | 161 ++++++++++++++++
 tb/tb_multicycle_control.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle processor control path: FSM states,
// opcodes and the ALUOp / ALU operand / PC source codes also used by ALUControl.
package cpu_ctrl_pkg;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR = 4'd2;
    localparam logic [3:0] ST_MEM_RD   = 4'd3;
    localparam logic [3:0] ST_MEM_WB   = 4'd4;
    localparam logic [3:0] ST_MEM_WR   = 4'd5;
    localparam logic [3:0] ST_EXEC_R   = 4'd6;
    localparam logic [3:0] ST_R_WB     = 4'd7;
    localparam logic [3:0] ST_EXEC_I   = 4'd8;
    localparam logic [3:0] ST_I_WB     = 4'd9;
    localparam logic [3:0] ST_BRANCH   = 4'd10;
    localparam logic [3:0] ST_JUMP     = 4'd11;

    typedef enum logic [3:0] {
        S_FETCH    = ST_FETCH,
        S_DECODE   = ST_DECODE,
        S_MEM_ADDR = ST_MEM_ADDR,
        S_MEM_RD   = ST_MEM_RD,
        S_MEM_WB   = ST_MEM_WB,
        S_MEM_WR   = ST_MEM_WR,
        S_EXEC_R   = ST_EXEC_R,
        S_R_WB     = ST_R_WB,
        S_EXEC_I   = ST_EXEC_I,
        S_I_WB     = ST_I_WB,
        S_BRANCH   = ST_BRANCH,
        S_JUMP     = ST_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_ONE    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the 16-bit multicycle processor: sequences
// fetch/decode/execute/memory/writeback and drives all datapath controls.
module multicycle_control
    import cpu_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_c,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;

    // Async reset lands in FETCH at once, dropping any in-flight memory request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        pc_write   = 1'b0;
        pc_write_c = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REGB;
        alu_op     = ALUOP_ADD;
        pc_source  = PCSRC_ALU;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                alu_src_b = SRCB_ONE;
                alu_op    = ALUOP_ADD;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode is decoded.
                alu_src_b = SRCB_IMM_SH;
                alu_op    = ALUOP_ADD;
                opcode_d  = opcode;
                if (is_mem_op(opcode)) begin
                    state_d = S_MEM_ADDR;
                end else begin
                    case (opcode)
                        OP_RTYPE: state_d = S_EXEC_R;
                        OP_ADDI:  state_d = S_EXEC_I;
                        OP_BEQ:   state_d = S_BRANCH;
                        OP_J:     state_d = S_JUMP;
                        default: begin
                            state_d    = S_FETCH;
                            illegal_op = 1'b1;
                            instr_done = 1'b1;
                        end
                    endcase
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                state_d   = (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                reg_dst    = 1'b0;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REGB;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                mem_to_reg = 1'b0;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b0;
                mem_to_reg = 1'b0;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_REGB;
                alu_op     = ALUOP_SUB;
                pc_write_c = 1'b1;
                pc_source  = PCSRC_ALUOUT;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instructions plus random instruction
// streams with random memory stalls, checked cycle by cycle against a micro-op plan.
module tb_multicycle_control;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_ADDI  = 6'b001000;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_c;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } outs_t;

    // One entry per instruction phase; waits = phase repeats while mem_ready is low.
    typedef struct {
        outs_t o;
        bit    waits;
        bit    gate_fetch;
        bit    gate_done;
    } step_t;

    logic       clock;
    logic       reset_n;
    logic [5:0] opcode;
    logic       mem_ready;
    outs_t      obs;

    logic pc_write, pc_write_c, i_or_d, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;

    int    checks;
    int    failures;
    step_t plan[$];

    multicycle_control dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_write_c (pc_write_c),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    assign obs = {pc_write, pc_write_c, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, instr_done, illegal_op};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic outs_t fetch_out(input logic mr);
        outs_t o;
        o = '0;
        o.mem_read  = 1'b1;
        o.alu_src_b = 2'b01;
        o.ir_write  = mr;
        o.pc_write  = mr;
        return o;
    endfunction

    function automatic int base_latency(input logic [5:0] op);
        case (op)
            T_LW:             return 5;
            T_SW:             return 4;
            T_RTYPE, T_ADDI:  return 4;
            T_BEQ, T_J:       return 3;
            default:          return 2;
        endcase
    endfunction

    function automatic void add(input outs_t o, input bit w, input bit gf, input bit gd);
        step_t s;
        s.o = o; s.waits = w; s.gate_fetch = gf; s.gate_done = gd;
        plan.push_back(s);
    endfunction

    // Micro-op sequence of one instruction, straight from the control table.
    function automatic void build(input logic [5:0] op);
        outs_t o;
        plan.delete();
        add(fetch_out(1'b0), 1'b1, 1'b1, 1'b0);
        o = '0; o.alu_src_b = 2'b11;
        if (base_latency(op) == 2) begin
            o.illegal_op = 1'b1; o.instr_done = 1'b1;
            add(o, 1'b0, 1'b0, 1'b0);
            return;
        end
        add(o, 1'b0, 1'b0, 1'b0);
        case (op)
            T_LW, T_SW: begin
                o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                add(o, 1'b0, 1'b0, 1'b0);
                if (op == T_LW) begin
                    o = '0; o.i_or_d = 1'b1; o.mem_read = 1'b1;
                    add(o, 1'b1, 1'b0, 1'b0);
                    o = '0; o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
                    add(o, 1'b0, 1'b0, 1'b0);
                end else begin
                    o = '0; o.i_or_d = 1'b1; o.mem_write = 1'b1;
                    add(o, 1'b1, 1'b0, 1'b1);
                end
            end
            T_RTYPE, T_ADDI: begin
                o = '0; o.alu_src_a = 1'b1;
                o.alu_src_b = (op == T_RTYPE) ? 2'b00 : 2'b10;
                o.alu_op    = (op == T_RTYPE) ? 2'b10 : 2'b00;
                add(o, 1'b0, 1'b0, 1'b0);
                o = '0; o.reg_write = 1'b1; o.reg_dst = (op == T_RTYPE); o.instr_done = 1'b1;
                add(o, 1'b0, 1'b0, 1'b0);
            end
            T_BEQ: begin
                o = '0; o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_c = 1'b1;
                o.pc_source = 2'b01; o.instr_done = 1'b1;
                add(o, 1'b0, 1'b0, 1'b0);
            end
            default: begin
                o = '0; o.pc_write = 1'b1; o.pc_source = 2'b10; o.instr_done = 1'b1;
                add(o, 1'b0, 1'b0, 1'b0);
            end
        endcase
    endfunction

    // Entered and left at posedge+1 with the DUT in FETCH. forced >= 0 gives
    // exactly that many stalls in each memory phase and none in FETCH.
    task automatic run_instr(input logic [5:0] op, input int stall_pct, input int forced);
        int    cyc;
        int    stalls;
        int    done_cyc;
        outs_t e;
        logic  mr;
        build(op);
        cyc = 0; stalls = 0; done_cyc = 0;
        for (int i = 0; i < plan.size(); i++) begin
            int tries;
            tries = 0;
            forever begin
                if (!plan[i].waits)
                    mr = 1'($urandom);
                else if (forced >= 0)
                    mr = (i != 0 && tries < forced) ? 1'b0 : 1'b1;
                else
                    mr = (tries < 3 && $urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
                mem_ready = mr;
                opcode    = (i == 1) ? op : 6'($urandom);
                @(negedge clock);
                e = plan[i].o;
                if (plan[i].gate_fetch) begin e.ir_write = mr; e.pc_write = mr; end
                if (plan[i].gate_done)  e.instr_done = mr;
                cyc++;
                chk($sformatf("op%b_step%0d_cyc%0d", op, i, cyc), 32'(obs), 32'(e));
                if (instr_done && done_cyc == 0) done_cyc = cyc;
                @(posedge clock); #1;
                if (!plan[i].waits || mr) break;
                stalls++; tries++;
            end
        end
        chk($sformatf("op%b_latency", op), 32'(done_cyc), 32'(base_latency(op) + stalls));
    endtask

    initial begin
        outs_t e;
        logic [5:0] ops [6];
        checks = 0; failures = 0;
        ops = '{T_RTYPE, T_LW, T_SW, T_BEQ, T_J, T_ADDI};

        reset_n = 1'b0; mem_ready = 1'b0; opcode = '0;
        #2;
        chk("reset_state", 32'(obs), 32'(fetch_out(1'b0)));
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;

        run_instr(T_RTYPE, 0, 0);
        run_instr(T_ADDI,  0, 0);
        run_instr(T_LW,    0, 2);
        run_instr(T_SW,    0, 0);
        run_instr(T_SW,    0, 1);
        run_instr(T_BEQ,   0, 0);
        run_instr(T_J,     0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(T_LW,    0, 0);

        // Reset asserted in the middle of a stalled load.
        mem_ready = 1'b1; opcode = T_LW;
        @(posedge clock); #1;
        @(posedge clock); #1;
        opcode = 6'b111111;
        @(posedge clock); #1;
        mem_ready = 1'b0;
        #2;
        e = '0; e.i_or_d = 1'b1; e.mem_read = 1'b1;
        chk("pre_reset_memrd", 32'(obs), 32'(e));
        reset_n = 1'b0;
        #1;
        chk("reset_mid_memrd", 32'(obs), 32'(fetch_out(1'b0)));
        @(posedge clock); #1;
        chk("reset_held", 32'(obs), 32'(fetch_out(1'b0)));
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        run_instr(T_BEQ, 0, 0);

        for (int n = 0; n < 80; n++) begin
            int r;
            r = int'($urandom_range(7));
            if (r < 6) run_instr(ops[r], 40, -1);
            else       run_instr(6'($urandom), 40, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
